// File: rtl/debounce_scan_ctrl_if.sv
// Event-drain handshake bundle for debounce_scan_ctrl: FIFO head, valid/ready
// and the sticky overflow flag with its clear strobe.
interface debounce_scan_ctrl_if #(
    parameter int NUM_BTN = 4
);
    localparam int ID_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [1:0]      evt_kind;
    logic [ID_W-1:0] evt_id;
    logic            evt_ovf;
    logic            ovf_clr;

    modport master (
        output evt_valid, evt_kind, evt_id, evt_ovf,
        input  evt_ready, ovf_clr
    );

    modport slave (
        input  evt_valid, evt_kind, evt_id, evt_ovf,
        output evt_ready, ovf_clr
    );
endinterface

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed button debouncer: one prescaler tick triggers a scan that
// visits each button once; commits go to an event FIFO. Optional long-press
// events are built when DEBOUNCE_SCAN_LONGPRESS_EN is defined.
module debounce_scan_ctrl #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 2500,
    parameter int STABLE_TICKS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int LONG_TICKS   = 1000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_db,
    debounce_scan_ctrl_if.master evt
);
    localparam int ID_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    idx, idx_nxt;
    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic [NUM_BTN-1:0] sync_a, sync_b;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic               differs, commit, push_req;
    logic [1:0]         push_kind;
    logic [PTR_W:0]     wptr, rptr;
    logic [ID_W+1:0]    mem [FIFO_DEPTH];
    logic               empty, full, pop, do_push, drop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    assign tick = (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: if (tick) begin
                state_nxt = SCAN;
                idx_nxt   = '0;
            end
            SCAN: if (idx == ID_W'(NUM_BTN - 1)) state_nxt = IDLE;
                  else idx_nxt = idx + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DEBOUNCE_SCAN_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    logic [HOLD_W-1:0] hold [NUM_BTN];

    // Hold counts scans while pressed and saturates so the long event fires once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) hold[i] <= '0;
        end else if (state == SCAN) begin
            if (commit)
                hold[idx] <= '0;
            else if (btn_db[idx] && hold[idx] != HOLD_W'(LONG_TICKS))
                hold[idx] <= hold[idx] + 1'b1;
        end
    end
`endif

    always_comb begin
        differs   = 1'b0;
        commit    = 1'b0;
        push_req  = 1'b0;
        push_kind = 2'b00;
        if (state == SCAN) begin
            differs   = (sync_b[idx] != btn_db[idx]);
            commit    = differs && (cnt[idx] == CNT_W'(STABLE_TICKS - 1));
            push_req  = commit;
            push_kind = {1'b0, sync_b[idx]};
`ifdef DEBOUNCE_SCAN_LONGPRESS_EN
            if (!commit && btn_db[idx] && hold[idx] == HOLD_W'(LONG_TICKS - 1)) begin
                push_req  = 1'b1;
                push_kind = 2'b10;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_db <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
        end else if (state == SCAN) begin
            if (!differs) begin
                cnt[idx] <= '0;
            end else if (commit) begin
                btn_db[idx] <= sync_b[idx];
                cnt[idx]    <= '0;
            end else begin
                cnt[idx] <= cnt[idx] + 1'b1;
            end
        end
    end

    // Extra pointer bit separates full from empty; a pop frees the slot a full push needs.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign pop     = !empty && evt.evt_ready;
    assign do_push = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[PTR_W-1:0]] <= {push_kind, idx};
                wptr                 <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         evt.evt_ovf <= 1'b0;
        else if (drop)        evt.evt_ovf <= 1'b1;
        else if (evt.ovf_clr) evt.evt_ovf <= 1'b0;
    end

    assign evt.evt_valid = !empty;
    assign {evt.evt_kind, evt.evt_id} = mem[rptr[PTR_W-1:0]];
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Randomized bench for debounce_scan_ctrl against a per-scan behavioural model
// with a queue-based event FIFO.
module tb_debounce_scan_ctrl;
    localparam int NUM_BTN      = 4;
    localparam int TICK_DIV     = 8;
    localparam int STABLE_TICKS = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int LONG_TICKS   = 5;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] btn_in;
    logic [3:0] btn_db;

    debounce_scan_ctrl_if #(.NUM_BTN(NUM_BTN)) evt_if ();

    debounce_scan_ctrl #(
        .NUM_BTN(NUM_BTN), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
        .FIFO_DEPTH(FIFO_DEPTH), .LONG_TICKS(LONG_TICKS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .btn_in(btn_in), .btn_db(btn_db), .evt(evt_if)
    );

    always #5 clock = ~clock;

    int         checks, errors, cyc;
    logic [3:0] m_db, lvl_seen, btn_target;
    int         run [4];
    int         hold [4];
    logic [3:0] mq [$];
    bit         m_ovf, ready_d, clr_d, clr_req;
    int         ready_pct;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_db = '0; m_ovf = 0; ready_d = 0; clr_d = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; hold[i] = 0; end
    endtask

    // Effects of the rising edge numbered cyc (edge 1 is the first after reset release).
    // Ticks land on edges 8k, so button i is scanned on edge 8k+1+i for k >= 1.
    task automatic modelEdge();
        bit         has_push, full_b, pop_now, committed;
        logic [3:0] ev;
        int         i;
        has_push = 0; committed = 0; ev = '0;
        if (cyc % TICK_DIV == 0) lvl_seen = btn_in;
        if (cyc > TICK_DIV && cyc % TICK_DIV >= 1 && cyc % TICK_DIV <= NUM_BTN) begin
            i = cyc % TICK_DIV - 1;
            if (lvl_seen[i] == m_db[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == STABLE_TICKS) begin
                    m_db[i]   = lvl_seen[i];
                    run[i]    = 0;
                    has_push  = 1;
                    committed = 1;
                    ev        = {1'b0, lvl_seen[i], 2'(i)};
                end
            end
`ifdef DEBOUNCE_SCAN_LONGPRESS_EN
            if (committed) hold[i] = 0;
            else if (m_db[i] && hold[i] < LONG_TICKS) begin
                hold[i]++;
                if (hold[i] == LONG_TICKS) begin
                    has_push = 1;
                    ev       = {2'b10, 2'(i)};
                end
            end
`endif
        end
        pop_now = (mq.size() > 0) && ready_d;
        full_b  = (mq.size() == FIFO_DEPTH);
        if (has_push && full_b && !pop_now) m_ovf = 1;
        else if (clr_d) m_ovf = 0;
        if (pop_now) void'(mq.pop_front());
        if (has_push && (!full_b || pop_now)) mq.push_back(ev);
    endtask

    task automatic compareAll();
        checkOutput("btn_db", 32'(btn_db), 32'(m_db));
        checkOutput("evt_valid", 32'(evt_if.evt_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("evt_kind", 32'(evt_if.evt_kind), 32'(mq[0][3:2]));
            checkOutput("evt_id", 32'(evt_if.evt_id), 32'(mq[0][1:0]));
        end
        checkOutput("evt_ovf", 32'(evt_if.evt_ovf), 32'(m_ovf));
    endtask

    task automatic applyStimulus();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        modelEdge();
        compareAll();
        if (cyc % TICK_DIV == 5) btn_in = btn_target;
        evt_if.evt_ready = ($urandom_range(99) < ready_pct);
        evt_if.ovf_clr   = clr_req;
        clr_req = 0;
        ready_d = evt_if.evt_ready;
        clr_d   = evt_if.ovf_clr;
    endtask

    task automatic runFrames(input int n);
        repeat (n * TICK_DIV) applyStimulus();
    endtask

    task automatic doReset(input logic [3:0] btn_now);
        reset_n = 1'b0;
        btn_in = btn_now;
        btn_target = btn_now;
        evt_if.evt_ready = 1'b0;
        evt_if.ovf_clr = 1'b0;
        #1;
        checkOutput("rst_btn_db", 32'(btn_db), 32'h0);
        checkOutput("rst_evt_valid", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("rst_evt_kind", 32'(evt_if.evt_kind), 32'h0);
        checkOutput("rst_evt_id", 32'(evt_if.evt_id), 32'h0);
        checkOutput("rst_evt_ovf", 32'(evt_if.evt_ovf), 32'h0);
        repeat (2) @(negedge clock);
        modelReset();
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; ready_pct = 0; clr_req = 0;
        reset_n = 1'b1; btn_in = '0; btn_target = '0;
        evt_if.evt_ready = 1'b0; evt_if.ovf_clr = 1'b0;
        modelReset();
        #2;
        doReset(4'h0);

        // Glitch of two ticks, then a real press of four ticks.
        ready_pct = 100;
        runFrames(2);
        btn_target = 4'b0100; runFrames(2);
        btn_target = 4'b0000; runFrames(4);
        btn_target = 4'b0100; runFrames(4);
        btn_target = 4'b0000; runFrames(5);

        // Handshake: queue events with the consumer stalled, then drain.
        ready_pct = 0;
        btn_target = 4'b0011; runFrames(5);
        ready_pct = 100; runFrames(1);

        // Overflow: six events into four slots, clear, then push while popping.
        ready_pct = 0;
        btn_target = 4'b0000; runFrames(4);
        btn_target = 4'b1111; runFrames(5);
        clr_req = 1; runFrames(1);
        ready_pct = 100;
        btn_target = 4'b0000; runFrames(5);

        // Long hold on button 1, then release.
        btn_target = 4'b0010; runFrames(12);
        btn_target = 4'b0000; runFrames(5);

        // Reset in the middle of a scan with every button held.
        btn_target = 4'b1111; runFrames(5);
        btn_target = 4'b0101; runFrames(1);
        while (cyc % TICK_DIV != 2) applyStimulus();
        doReset(4'hF);
        runFrames(6);

        // Random levels, consumer rates and overflow clears.
        for (int f = 0; f < 200; f++) begin
            if (f % 10 == 0) ready_pct = $urandom_range(3) * 33;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(99) < 20) btn_target[b] = ~btn_target[b];
            if ($urandom_range(99) < 5) clr_req = 1;
            runFrames(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Time-multiplexed debounce scheduler for NUM_BTN front-panel buttons.
- One shared sample-tick prescaler and one scan FSM visit every button once per tick. The FSM updates a per-button stability counter and commits debounced levels.
- Press/release events go into a small FIFO, drained over a valid/ready handshake.
- Sits between raw board pins and the Propeller-side input register logic. It replaces per-button free-running debounce counters.

Parameters:
- NUM_BTN, 4, number of buttons scanned (2..16).
- TICK_DIV, 2500, clocks per sample tick; must be > NUM_BTN + 1.
- STABLE_TICKS, 8, consecutive disagreeing samples needed to commit a new level (2..255).
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- LONG_TICKS, 1000, ticks held before a long-press event (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset; release is synchronised externally.
- btn_in  in  NUM_BTN  raw asynchronous button levels; active-high.
- btn_db  out  NUM_BTN  debounced levels.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_kind  out  2  00 release, 01 press, 10 long-press, 11 unused.
- evt_id  out  max(1,$clog2(NUM_BTN))  button index of the head event.
- evt_ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears evt_ovf.

Behaviour:
- Reset values (async, while reset_n=0):
  - btn_db=0, evt_valid=0, evt_kind=0, evt_id=0, evt_ovf=0.
  - Prescaler, FSM, counters, sync flops and FIFO pointers all return to 0 / IDLE.
  - Any scan in progress is abandoned.
- Input synchronisation: each btn_in bit passes through 2 flops (sync[i]). The FSM reads only sync[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is 1 for the single cycle where count = TICK_DIV-1.
- FSM states: IDLE, SCAN.
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: process button idx in one cycle. If idx = NUM_BTN-1, go to IDLE; otherwise idx+1.
  - A scan therefore takes NUM_BTN cycles and always completes before the next tick.
- Per-button processing (cnt[i] is $clog2(STABLE_TICKS+1) bits wide):
  - sync[i] = btn_db[i]: cnt[i] <- 0.
  - Otherwise, if cnt[i] = STABLE_TICKS-1: btn_db[i] <- sync[i], cnt[i] <- 0, and push event (kind = 01 on rise, 00 on fall; id = i).
  - Otherwise: cnt[i] <- cnt[i]+1.
- Latency: a clean level change commits on the STABLE_TICKS-th scan after it reaches sync. A glitch shorter than STABLE_TICKS scans produces no event and no btn_db change.
- Push arbitration: at most one push per cycle, because only one button is processed per cycle. No further arbitration is needed.
- FIFO:
  - First-word-fallthrough. evt_valid = not empty; evt_kind/evt_id show the head combinationally from registered storage.
  - Pop when evt_valid & evt_ready.
  - Push when not full, or when full and popping in the same cycle (both take effect, occupancy unchanged).
  - Push while full without a pop: the event is dropped and evt_ovf <- 1. btn_db still updates.
  - Push and pop while empty: no bypass; evt_valid rises the next cycle.
  - evt_ready while empty is ignored.
- evt_ovf: set has priority over ovf_clr in the same cycle.

Optional Feature:
- Macro: DEBOUNCE_SCAN_LONGPRESS_EN.
- Defined:
  - Each button has a hold[i] counter, $clog2(LONG_TICKS+1) bits wide.
  - hold[i] is reset to 0 when btn_db[i] commits 1 and increments at each scan of button i while btn_db[i]=1.
  - When hold[i] reaches LONG_TICKS, push a kind=10 event for i, once per press; hold[i] then saturates.
  - A release clears hold[i]. The release event is still pushed.
  - The long-press push uses the same single push slot and the same overflow rule.
- Undefined: no hold counters are built and kind 10 is never produced.

Test Plan:
- Bench parameters: NUM_BTN=4, TICK_DIV=8, STABLE_TICKS=3, FIFO_DEPTH=4, LONG_TICKS=5.
- Reset: drive reset_n=0 mid-scan with btn_in=4'b1111 -> all outputs 0 immediately; after release, btn_db=4'b1111 only after 3 scans, with 4 press events in order id 0,1,2,3.
- Glitch: hold btn_in[2] high for 2 ticks, then low -> no event, btn_db[2] stays 0; high for 4 ticks -> exactly one {01,id=2}, btn_db[2]=1.
- Handshake: evt_ready=0 while 2 events queue -> evt_valid=1, head is the first event; then evt_ready=1 for 2 cycles -> events pop in order, evt_valid drops to 0.
- Overflow: evt_ready=0, generate 5 events -> FIFO holds the first 4 and evt_ovf=1; ovf_clr pulse -> evt_ovf=0; pop-and-push while full -> no drop, occupancy stays 4.
- Long press (macro on): hold btn 1 for 10 ticks -> {01,1} then exactly one {10,1}; release -> {00,1}. Macro off: no kind 10 event is produced.
